// File: rtl/req_burst_reader.sv
// req_burst_reader: bus initiator that fetches a block of 32-bit words in
// line-aligned read bursts and presents them on a first-word-fall-through
// valid/ready output stream.
module req_burst_reader #(
  parameter int unsigned BURST      = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned COUNT_W    = 20
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [31:0]        req_addr,
  output logic [2:0]         req_len,
  output logic [3:0]         req_mask,
  output logic               req_we,
  output logic               write_valid,
  input  logic               read_valid,
  input  logic [31:0]        read_data,
  output logic               read_ack,
  output logic               out_valid,
  output logic [31:0]        out_data,
  input  logic               out_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_REQ,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [COUNT_W-1:0] r_rem;
  logic               r_abort_pend;
  logic [3:0]         r_beat_cnt;
  logic               r_done;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic [3:0]         w_off;
  logic [3:0]         w_room;
  logic [3:0]         w_beats;
  logic [CW-1:0]      w_free;
  logic               w_space_ok;
  logic               w_last_beat;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_start_ok;
  logic               w_unused;

  // Byte-lane bits of the base address carry no information for word fetches.
  assign w_unused = ^base_addr[1:0];

  // Burst sizing: stop at the end of the current BURST-word line or at the
  // end of the block, whichever comes first.
  assign w_off   = 4'(r_addr[31:2] % 30'(BURST));
  assign w_room  = 4'(BURST) - w_off;
  assign w_beats = (COUNT_W'(w_room) > r_rem) ? 4'(r_rem) : w_room;

  assign w_free      = CW'(FIFO_DEPTH) - r_count;
  assign w_space_ok  = (w_free >= CW'(w_beats));
  assign w_last_beat = read_valid && (r_beat_cnt == (w_beats - 4'd1));
  assign w_push      = (r_state == S_DATA) && read_valid;
  assign w_pop       = (r_count != '0) && out_ready;
  assign w_flush     = (r_state == S_DRAIN) && r_abort_pend;
  assign w_start_ok  = (r_state == S_IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (word_count != '0)) w_next = S_WAIT_SPACE;
      end
      S_WAIT_SPACE: begin
        if (r_abort_pend)    w_next = S_DRAIN;
        else if (w_space_ok) w_next = S_REQ;
      end
      S_REQ: begin
        if (req_ready) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_last_beat) begin
          if ((r_rem == COUNT_W'(w_beats)) || r_abort_pend) w_next = S_DRAIN;
          else                                               w_next = S_WAIT_SPACE;
        end
      end
      S_DRAIN: begin
        if (r_abort_pend || (r_count == '0)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: address, remaining words, beat count, abort, done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr       <= '0;
      r_rem        <= '0;
      r_abort_pend <= 1'b0;
      r_beat_cnt   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (w_start_ok && (word_count == '0)) ||
                ((r_state == S_DRAIN) && (w_next == S_IDLE));
      if (w_start_ok) begin
        r_addr       <= {base_addr[31:2], 2'b00};
        r_rem        <= word_count;
        r_abort_pend <= 1'b0;
      end else if (abort && (r_state != S_IDLE)) begin
        r_abort_pend <= 1'b1;
      end
      if (w_push) begin
        if (w_last_beat) begin
          r_beat_cnt <= '0;
          r_addr     <= r_addr + {26'd0, w_beats, 2'b00};
          r_rem      <= r_rem - COUNT_W'(w_beats);
        end else begin
          r_beat_cnt <= r_beat_cnt + 4'd1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; an abort flush empties it in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; space for every beat was reserved before the request.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= read_data;
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign req_valid   = (r_state == S_REQ);
  assign req_addr    = req_valid ? r_addr : '0;
  assign req_len     = req_valid ? 3'(w_beats - 4'd1) : '0;
  assign req_mask    = 4'hF;
  assign req_we      = 1'b0;
  assign write_valid = 1'b0;
  assign read_ack    = (r_state == S_DATA) && read_valid;
  assign out_valid   = (r_count != '0);
  // Empty FIFO shows zero data so the stream idles at a defined value.
  assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_req_burst_reader.sv
// Self-checking bench for req_burst_reader: table of transfers plus
// hand-written corner sequences, with a read-target model and a
// scoreboard of expected stream words.
module tb_req_burst_reader;

  localparam int unsigned BURST      = 4;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned COUNT_W    = 20;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic [31:0]        base_addr = '0;
  logic [COUNT_W-1:0] word_count = '0;
  logic               abort = 1'b0;
  logic               busy, done;
  logic               req_valid;
  logic               req_ready = 1'b0;
  logic [31:0]        req_addr;
  logic [2:0]         req_len;
  logic [3:0]         req_mask;
  logic               req_we, write_valid;
  logic               read_valid = 1'b0;
  logic [31:0]        read_data = '0;
  logic               read_ack;
  logic               out_valid;
  logic [31:0]        out_data;
  logic               out_ready = 1'b0;

  req_burst_reader #(.BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_mask(req_mask), .req_we(req_we),
    .write_valid(write_valid), .read_valid(read_valid), .read_data(read_data),
    .read_ack(read_ack), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic [31:0] log_addr[$];
  logic [2:0]  log_len[$];

  int rr_mode = 0;   // 0: fixed gap, 1: random
  int rr_gap  = 0;
  int rv_mode = 0;   // 0: back-to-back beats, 1: random gaps
  int ov_mode = 1;   // 0: hold low, 1: always ready, 2: random
  int done_cnt = 0;
  int ack_cnt  = 0;
  bit expect_empty = 1'b1;

  bit          s_active = 1'b0;
  logic [31:0] s_addr = '0;
  int          s_left = 0;
  int          wait_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [2:0]  prev_len = '0;

  typedef struct {
    logic [31:0] base;
    int          cnt;
    int          gap;
    int          ov;
    int          rv;
    int          nreq;
    logic [31:0] a0;
    logic [2:0]  l0;
    logic [31:0] a1;
    logic [2:0]  l1;
  } vec_t;

  vec_t vt[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Read target + stream consumer + scoreboard, all decided at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        s_active = 1'b0; prev_stall = 1'b0; wait_cnt = 0;
        req_ready = 1'b0; read_valid = 1'b0;
        continue;
      end
      if (rr_mode == 1) begin
        req_ready = 1'($urandom_range(0, 1));
      end else if (req_valid) begin
        req_ready = (wait_cnt >= rr_gap);
        wait_cnt++;
      end else begin
        req_ready = 1'b0;
      end
      read_valid = s_active && ((rv_mode == 0) || ($urandom_range(0, 2) != 0));
      read_data  = mem_word(s_addr);
      out_ready  = (ov_mode == 0) ? 1'b0 : (ov_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        chk("req_hold_valid", {31'd0, req_valid}, 32'd1);
        chk("req_hold_addr", req_addr, prev_addr);
        chk("req_hold_len", {29'd0, req_len}, {29'd0, prev_len});
      end
      prev_stall = req_valid && !req_ready;
      prev_addr  = req_addr;
      prev_len   = req_len;
      if (req_valid && req_ready) begin
        log_addr.push_back(req_addr);
        log_len.push_back(req_len);
        s_active = 1'b1;
        s_addr   = req_addr;
        s_left   = int'(req_len) + 1;
        wait_cnt = 0;
      end
      if (read_valid) begin
        chk("read_ack", {31'd0, read_ack}, 32'd1);
        ack_cnt++;
        s_addr = s_addr + 32'd4;
        s_left--;
        if (s_left == 0) s_active = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word got=%0h want=none", out_data);
        end else begin
          chk("out_data", out_data, sb.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (expect_empty) chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_req_valid"}, {31'd0, req_valid}, 32'd0);
    chk({tag, "_req_addr"}, req_addr, 32'd0);
    chk({tag, "_req_len"}, {29'd0, req_len}, 32'd0);
    chk({tag, "_req_mask"}, {28'd0, req_mask}, 32'hF);
    chk({tag, "_req_we"}, {31'd0, req_we}, 32'd0);
    chk({tag, "_write_valid"}, {31'd0, write_valid}, 32'd0);
    chk({tag, "_read_ack"}, {31'd0, read_ack}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
  endtask

  task automatic start_xfer(input logic [31:0] b, input int n);
    logic [31:0] a0;
    a0 = b & ~32'h3;
    for (int i = 0; i < n; i++) sb.push_back(mem_word(a0 + 32'(i) * 32'd4));
    @(negedge clk);
    base_addr  = b;
    word_count = COUNT_W'(n);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while ((done_cnt == 0) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=no_done want=done", tag);
    end
  endtask

  // Expected burst list from the line-splitting rule.
  task automatic check_reqs(input logic [31:0] b, input int n, input string tag);
    logic [31:0] a;
    int rem, beats, idx;
    a = b & ~32'h3; rem = n; idx = 0;
    while (rem > 0) begin
      beats = int'(BURST) - int'((a >> 2) % BURST);
      if (beats > rem) beats = rem;
      if (idx < log_addr.size()) begin
        chk({tag, "_req_addr"}, log_addr[idx], a);
        chk({tag, "_req_len"}, {29'd0, log_len[idx]}, 32'(beats - 1));
      end
      idx++;
      a = a + 32'(beats * 4);
      rem -= beats;
    end
    chk({tag, "_nreq"}, 32'(log_addr.size()), 32'(idx));
  endtask

  task automatic clear_run();
    log_addr.delete(); log_len.delete();
    done_cnt = 0; ack_cnt = 0; expect_empty = 1'b1;
    rr_mode = 0; rr_gap = 0; rv_mode = 0; ov_mode = 1;
  endtask

  initial begin
    vt[0] = '{32'h4000_0000, 8, 0, 1, 0, 2, 32'h4000_0000, 3'd3, 32'h4000_0010, 3'd3};
    vt[1] = '{32'h0000_0008, 5, 3, 1, 0, 2, 32'h0000_0008, 3'd1, 32'h0000_0010, 3'd2};
    vt[2] = '{32'h0000_000B, 3, 1, 2, 1, 2, 32'h0000_0008, 3'd1, 32'h0000_0010, 3'd0};
    vt[3] = '{32'hFFFF_FFF4, 6, 0, 2, 1, 2, 32'hFFFF_FFF4, 3'd2, 32'h0000_0000, 3'd2};
    vt[4] = '{32'h0000_0100, 1, 2, 1, 0, 1, 32'h0000_0100, 3'd0, 32'h0000_0000, 3'd0};
    vt[5] = '{32'h0000_001C, 9, 0, 2, 0, 3, 32'h0000_001C, 3'd0, 32'h0000_0020, 3'd3};

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transfers.
    for (int v = 0; v < 6; v++) begin
      clear_run();
      rr_gap = vt[v].gap; ov_mode = vt[v].ov; rv_mode = vt[v].rv;
      start_xfer(vt[v].base, vt[v].cnt);
      wait_done(2000, "vec");
      repeat (3) @(negedge clk);
      chk("vec_nreq", 32'(log_addr.size()), 32'(vt[v].nreq));
      if (log_addr.size() > 0) begin
        chk("vec_addr0", log_addr[0], vt[v].a0);
        chk("vec_len0", {29'd0, log_len[0]}, {29'd0, vt[v].l0});
      end
      if ((vt[v].nreq > 1) && (log_addr.size() > 1)) begin
        chk("vec_addr1", log_addr[1], vt[v].a1);
        chk("vec_len1", {29'd0, log_len[1]}, {29'd0, vt[v].l1});
      end
      check_reqs(vt[v].base, vt[v].cnt, "vec");
      chk("vec_done_cnt", 32'(done_cnt), 32'd1);
      chk("vec_sb_empty", 32'(sb.size()), 32'd0);
      chk("vec_busy_after", {31'd0, busy}, 32'd0);
    end

    // Zero-length transfer: done on the next cycle, no request.
    clear_run();
    @(negedge clk);
    base_addr = 32'h0000_0040; word_count = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("zero_nreq", 32'(log_addr.size()), 32'd0);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);

    // Start while busy is ignored.
    clear_run();
    rr_gap = 2;
    start_xfer(32'h0000_2000, 8);
    repeat (3) @(negedge clk);
    base_addr = 32'h0000_9000; word_count = COUNT_W'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, "restart");
    repeat (3) @(negedge clk);
    check_reqs(32'h0000_2000, 8, "restart");
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);
    chk("restart_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: a stalled consumer limits issue to a FIFO's worth.
    clear_run();
    ov_mode = 0;
    start_xfer(32'h0000_0000, 32);
    repeat (100) @(negedge clk);
    chk("bp_nreq_stalled", 32'(log_addr.size()), 32'd4);
    chk("bp_req_valid", {31'd0, req_valid}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_sb_full", 32'(sb.size()), 32'd32);
    ov_mode = 1;
    wait_done(2000, "bp");
    repeat (3) @(negedge clk);
    check_reqs(32'h0000_0000, 32, "bp");
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Abort during the third burst's data phase.
    clear_run();
    expect_empty = 1'b0;
    start_xfer(32'h0000_1000, 64);
    begin
      int k;
      k = 0;
      while ((ack_cnt < 9) && (k < 500)) begin
        @(negedge clk);
        k++;
      end
      if (ack_cnt < 9) begin
        checks++; errors++;
        $display("FAIL abort_wait got=%0d want=9", ack_cnt);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(500, "abort");
    repeat (5) @(negedge clk);
    chk("abort_nreq", 32'(log_addr.size()), 32'd3);
    chk("abort_acks", 32'(ack_cnt), 32'd12);
    chk("abort_done_cnt", 32'(done_cnt), 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    sb.delete();

    // Normal transfer after an abort.
    clear_run();
    start_xfer(32'h0000_3000, 4);
    wait_done(500, "post_abort");
    repeat (3) @(negedge clk);
    check_reqs(32'h0000_3000, 4, "post_abort");
    chk("post_abort_done_cnt", 32'(done_cnt), 32'd1);
    chk("post_abort_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset while a request is pending.
    clear_run();
    rr_gap = 1000;
    start_xfer(32'h0000_5000, 8);
    begin
      int k;
      k = 0;
      while (!req_valid && (k < 50)) begin
        @(negedge clk);
        k++;
      end
      chk("rst_req_seen", {31'd0, req_valid}, 32'd1);
    end
    #3 rstn = 1'b0;
    #1 chk_reset_outputs("midreset");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rr_gap = 0;
    repeat (5) @(negedge clk);
    chk("midreset_done_cnt", 32'(done_cnt), 32'd0);
    chk("midreset_nreq", 32'(log_addr.size()), 32'd0);

    // Random gaps on every handshake over a long block.
    clear_run();
    rr_mode = 1; rv_mode = 1; ov_mode = 2;
    begin
      logic [31:0] rb;
      rb = $urandom() & ~32'h3;
      start_xfer(rb, 1000);
      wait_done(20000, "rand");
      repeat (3) @(negedge clk);
      check_reqs(rb, 1000, "rand");
    end
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_done_cnt", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_burst_reader.md
Name: req_burst_reader

Overview:
- Bus initiator on the SoC request interface: the requester end of the same valid/ready, length and read-data protocol that the CPU bridge drives into the request mux.
- Fetches a programmed block of 32-bit words from any request target, normally SDRAM, using line-sized read bursts.
- Buffers fetched words in an internal FIFO and presents them on a valid/ready output stream.
- First consumer is the VGA framebuffer path; an audio/DMA engine is the second.
- Single clock domain, sys_clk.

Parameters:
BURST, 4, maximum beats per request (1..8); 4 matches the 16-byte line.
FIFO_DEPTH, 16, output FIFO entries; power of two, >= BURST.
COUNT_W, 20, width of word_count.

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
start  in  1  one-cycle pulse; begins a transfer when idle
base_addr  in  32  byte start address; bits [1:0] ignored, treated as 0
word_count  in  COUNT_W  number of 32-bit words to fetch
abort  in  1  one-cycle pulse; stop the transfer early
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
req_valid  out  1  request valid
req_ready  in  1  target accepts request
req_addr  out  32  word-aligned byte address of first beat
req_len  out  3  beats-1
req_mask  out  4  byte mask, constant 4'hF
req_we  out  1  constant 0
write_valid  out  1  constant 0
read_valid  in  1  read beat available
read_data  in  32  read beat
read_ack  out  1  beat consumed
out_valid  out  1  stream word available
out_data  out  32  stream word
out_ready  in  1  consumer takes word

Behaviour:
- Reset values: all outputs 0 except req_mask=4'hF; FIFO empty; state IDLE.
- Reset mid-transfer aborts immediately with no done pulse.
- Latched at start (IDLE only): cur_addr = {base_addr[31:2],2'b00}, remaining = word_count, abort_pend = 0.
- start while busy is ignored; parameters are not re-latched.
- Burst size: beats = min(BURST - cur_addr[3:2] offset within a BURST*4-byte line, remaining). Bursts never cross a line boundary, so the first and last bursts may be short.
- FSM states and transitions:
  - IDLE: start with word_count!=0 -> WAIT_SPACE and busy=1. start with word_count==0 -> busy stays 0, done=1 on the next cycle, no request.
  - WAIT_SPACE: abort_pend -> DRAIN. Otherwise, once FIFO free entries >= beats -> REQ.
  - REQ: req_valid=1, req_addr=cur_addr, req_len=beats-1. Hold all three stable until req_valid&req_ready. Never withdraw, even if abort arrives. On accept -> DATA.
  - DATA: read_ack = read_valid (combinational); every valid beat is pushed into the FIFO (space was reserved beforehand). Count beats. After the final beat: cur_addr += 4*beats, remaining -= beats. Then: remaining==0 or abort_pend -> DRAIN, else -> WAIT_SPACE.
  - DRAIN: if abort_pend, flush the FIFO in one cycle and go to IDLE. Otherwise wait until the FIFO is empty (last word popped), then -> IDLE. On the DRAIN->IDLE transition: done=1 for one cycle, busy=0.
- Only one request outstanding at a time.
- abort: sets abort_pend in any busy state. The accepted burst still completes on the bus (its data is discarded by the flush). Ignored in IDLE.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0); out_data = entry at the read pointer.
  - A beat accepted in cycle N appears on out_valid in cycle N+1.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
  - A pop while empty is impossible because out_valid=0.
- out_valid may stay high after done only if the FIFO was not drained. This cannot happen in normal completion, since done waits for empty.
- Address arithmetic wraps modulo 2^32. remaining never underflows.

Test Plan:
- Aligned fetch: base 0x4000_0000, count 8, target ready immediately, out_ready=1 -> two requests (0x4000_0000, len 3; 0x4000_0010, len 3); 8 words in order; done pulses exactly once after the 8th pop; busy falls the same cycle.
- Unaligned/short: base 0x0000_0008, count 5 -> requests 0x08 len 1, 0x10 len 2 in that order; req_addr/req_len held stable while req_ready is held low for 3 cycles.
- Backpressure: FIFO_DEPTH 16, count 32, out_ready=0 -> exactly 4 bursts issued, then req_valid stays 0. Release out_ready -> remaining 4 bursts issue; all 32 words are delivered in order with none lost or duplicated.
- Abort: count 64; abort pulsed mid-DATA of the 3rd burst -> that burst completes (4 read_acks); no further req_valid; FIFO empties; done pulses; the next start works normally.
- Edge cases: start with count 0 -> done next cycle, no req_valid. start while busy is ignored. rstn asserted during REQ -> all outputs return to reset values asynchronously.
- Random: random req_ready/read_valid gaps and out_ready toggling over 1000 words -> output matches the memory model and req_valid never drops before req_ready.
